// File: rtl/td4_prog_loader.sv
// UART (8N1) program loader for the TD4 16x8 instruction RAM; holds the core in reset until an image is accepted.
// Optional checksum byte after the 16 data bytes is built when TD4_LOADER_CSUM_EN is defined.
module td4_prog_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_DATA  = 2'd2,
        B_STOP  = 2'd3
    } bstate_t;

    typedef enum logic [1:0] {
        L_SYNC = 2'd0,
        L_DATA = 2'd1,
`ifdef TD4_LOADER_CSUM_EN
        L_CSUM = 2'd2,
`endif
        L_DONE = 2'd3
    } lstate_t;

    // rx synchroniser; rx_p2 is the previous synchronised sample for edge detection
    logic rx_p0, rx_p1, rx_p2;
    logic rx_s, rx_fall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign rx_s    = rx_p1;
    assign rx_fall = rx_p2 & ~rx_p1;

    // bit-level receiver
    bstate_t          bstate, bstate_nxt;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_q, shift_nxt;
    logic             byte_stb, byte_stb_nxt;
    logic             frame_err, frame_err_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bstate    <= B_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bstate    <= bstate_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_q   <= shift_nxt;
            byte_stb  <= byte_stb_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        bstate_nxt    = bstate;
        clk_cnt_nxt   = clk_cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift_q;
        byte_stb_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        case (bstate)
            B_IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (rx_fall) bstate_nxt = B_START;
            end
            B_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    // a start bit that is high again at mid-bit was only a glitch
                    bstate_nxt  = rx_s ? B_IDLE : B_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            B_DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_s, shift_q[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) bstate_nxt = B_STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            B_STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_nxt   = '0;
                    byte_stb_nxt  = rx_s;
                    frame_err_nxt = ~rx_s;
                    bstate_nxt    = B_IDLE;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            default: bstate_nxt = B_IDLE;
        endcase
    end

    // frame-level loader; every output is registered, so it lags the byte strobe by one cycle
    lstate_t    lstate, lstate_nxt;
    logic [3:0] count, count_nxt;
    logic [7:0] sum, sum_nxt;
    logic       wr_en_nxt;
    logic [3:0] wr_addr_nxt;
    logic [7:0] wr_data_nxt;
    logic       busy_nxt, done_nxt, err_nxt, cpu_reset_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lstate    <= L_SYNC;
            count     <= '0;
            sum       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b0;
        end else begin
            lstate    <= lstate_nxt;
            count     <= count_nxt;
            sum       <= sum_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            cpu_reset <= cpu_reset_nxt;
        end
    end

    always_comb begin
        lstate_nxt  = lstate;
        count_nxt   = count;
        sum_nxt     = sum;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = err;
        case (lstate)
            L_SYNC, L_DONE: begin
                if (byte_stb && (shift_q == SYNC_BYTE)) begin
                    busy_nxt   = 1'b1;
                    err_nxt    = 1'b0;
                    count_nxt  = '0;
                    sum_nxt    = '0;
                    lstate_nxt = L_DATA;
                end
            end
            L_DATA: begin
                // framing error wins over the write for the same byte
                if (frame_err) begin
                    err_nxt    = 1'b1;
                    busy_nxt   = 1'b0;
                    lstate_nxt = L_SYNC;
                end else if (byte_stb) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = count;
                    wr_data_nxt = shift_q;
                    sum_nxt     = sum + shift_q;
                    count_nxt   = count + 4'd1;
                    if (count == 4'd15) begin
`ifdef TD4_LOADER_CSUM_EN
                        lstate_nxt = L_CSUM;
`else
                        lstate_nxt = L_DONE;
                        done_nxt   = 1'b1;
                        busy_nxt   = 1'b0;
`endif
                    end
                end
            end
`ifdef TD4_LOADER_CSUM_EN
            L_CSUM: begin
                if (frame_err) begin
                    err_nxt    = 1'b1;
                    busy_nxt   = 1'b0;
                    lstate_nxt = L_SYNC;
                end else if (byte_stb) begin
                    busy_nxt = 1'b0;
                    if (shift_q == sum) begin
                        lstate_nxt = L_DONE;
                        done_nxt   = 1'b1;
                    end else begin
                        err_nxt    = 1'b1;
                        lstate_nxt = L_SYNC;
                    end
                end
            end
`endif
            default: lstate_nxt = L_SYNC;
        endcase
        cpu_reset_nxt = (lstate_nxt == L_DONE);
    end

endmodule
